// File: rtl/dwrr_flow_queues_if.sv
// ---------------------------------------------------------------------------
// dwrr_flow_queues_if
// Bundles the signals between the per-flow packet queues and their
// environment: the upstream enqueue port, the request/grant pair shared
// with the DWRR arbiter, the dequeued-packet output port and status.
//
// Signals:
//   in_valid / in_flow / in_data / in_ready : upstream enqueue handshake
//   reqs / gnt                              : request vector to, and
//                                             one-hot grant from, the arbiter
//   out_valid / out_flow / out_data         : registered dequeued packet
//   occupancy                               : packed per-queue entry counts
//   gnt_err                                 : sticky grant protocol error
//
// Modports:
//   slave  : the queue block itself
//   master : the environment (sources, arbiter, packet sink)
// ---------------------------------------------------------------------------
interface dwrr_flow_queues_if #(
    parameter int NUM_REQS = 4,
    parameter int DWID     = 8,
    parameter int DEPTH    = 4,
    parameter int IDXW     = $clog2(NUM_REQS),
    parameter int OCCW     = $clog2(DEPTH + 1)
);
    logic                     in_valid;
    logic [IDXW-1:0]          in_flow;
    logic [DWID-1:0]          in_data;
    logic                     in_ready;
    logic [NUM_REQS-1:0]      reqs;
    logic [NUM_REQS-1:0]      gnt;
    logic                     out_valid;
    logic [IDXW-1:0]          out_flow;
    logic [DWID-1:0]          out_data;
    logic [NUM_REQS*OCCW-1:0] occupancy;
    logic                     gnt_err;

    modport slave (
        input  in_valid, in_flow, in_data, gnt,
        output in_ready, reqs, out_valid, out_flow, out_data, occupancy, gnt_err
    );

    modport master (
        output in_valid, in_flow, in_data, gnt,
        input  in_ready, reqs, out_valid, out_flow, out_data, occupancy, gnt_err
    );
endinterface

// File: rtl/dwrr_flow_queues.sv
// ---------------------------------------------------------------------------
// dwrr_flow_queues
// Requestor side of a DWRR arbiter. Holds NUM_REQS independent packet FIFOs
// of DEPTH entries each. Every non-empty FIFO raises its reqs bit; a valid
// one-hot grant pops the head of the granted FIFO into a registered output
// port one cycle later. Upstream sources enqueue by flow index.
//
// Ports:
//   clk  : single clock, all state updates on the rising edge
//   rst  : synchronous, active-low reset
//   bus  : dwrr_flow_queues_if.slave
//          in_valid/in_flow/in_data/in_ready - enqueue handshake
//                                              (in_ready is combinational)
//          reqs      - queue i non-empty, from registered counts only
//          gnt       - arbiter grant, one-hot or zero
//          out_valid/out_flow/out_data       - registered popped packet
//          occupancy - packed counts, queue i at [(i+1)*OCCW-1:i*OCCW]
//          gnt_err   - sticky: grant to an empty queue or multi-bit grant
// ---------------------------------------------------------------------------
module dwrr_flow_queues #(
    parameter int NUM_REQS = 4,
    parameter int DWID     = 8,
    parameter int DEPTH    = 4,
    parameter int IDXW     = $clog2(NUM_REQS),
    parameter int OCCW     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    dwrr_flow_queues_if.slave    bus
);

    // Pointer width covers 0..DEPTH-1; DEPTH need not be a power of two.
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Width able to hold a population count of the grant vector.
    localparam int CNTW = $clog2(NUM_REQS + 1);

    localparam logic [OCCW-1:0] FULL_CNT  = OCCW'(DEPTH);
    localparam logic [OCCW-1:0] ZERO_CNT  = {OCCW{1'b0}};
    localparam logic [OCCW-1:0] ONE_CNT   = OCCW'(1);
    localparam logic [PTRW-1:0] LAST_PTR  = PTRW'(DEPTH - 1);
    localparam logic [PTRW-1:0] ZERO_PTR  = {PTRW{1'b0}};
    localparam logic [PTRW-1:0] ONE_PTR   = PTRW'(1);
    localparam logic [CNTW-1:0] ONE_GNT   = CNTW'(1);

    // Advance a ring pointer, wrapping explicitly after the last entry so
    // non-power-of-two depths work.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] ptr);
        logic [PTRW-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = ZERO_PTR;
        end else begin
            nxt = ptr + ONE_PTR;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DWID-1:0] mem_r    [NUM_REQS][DEPTH];
    logic [PTRW-1:0] wr_ptr_r [NUM_REQS];
    logic [PTRW-1:0] rd_ptr_r [NUM_REQS];
    logic [OCCW-1:0] count_r  [NUM_REQS];

    logic            out_valid_r;
    logic [IDXW-1:0] out_flow_r;
    logic [DWID-1:0] out_data_r;
    logic            gnt_err_r;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [OCCW-1:0]          in_cnt_s;
    logic                     in_hit_s;
    logic                     in_ready_s;
    logic [NUM_REQS-1:0]      push_vec_s;
    logic [NUM_REQS-1:0]      pop_vec_s;
    logic [CNTW-1:0]          gnt_ones_s;
    logic [IDXW-1:0]          gnt_idx_s;
    logic [OCCW-1:0]          gnt_cnt_s;
    logic [DWID-1:0]          head_data_s;
    logic                     pop_valid_s;
    logic                     gnt_bad_s;
    logic [NUM_REQS-1:0]      reqs_s;
    logic [NUM_REQS*OCCW-1:0] occupancy_s;

    // Select the count of the addressed upstream flow; an index beyond
    // NUM_REQS never matches, so such a packet is never accepted.
    always_comb begin
        in_cnt_s = ZERO_CNT;
        in_hit_s = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (bus.in_flow == IDXW'(i)) begin
                in_cnt_s = count_r[i];
                in_hit_s = 1'b1;
            end else begin
                in_cnt_s = in_cnt_s;
                in_hit_s = in_hit_s;
            end
        end
    end

    // Readiness uses the pre-pop count: a full queue refuses a push even
    // when it is popped in the same cycle.
    always_comb begin
        if (rst && in_hit_s && (in_cnt_s != FULL_CNT)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // Grant decode: population count, granted index and that queue's head.
    always_comb begin
        gnt_ones_s  = {CNTW{1'b0}};
        gnt_idx_s   = {IDXW{1'b0}};
        gnt_cnt_s   = ZERO_CNT;
        head_data_s = {DWID{1'b0}};
        for (int i = 0; i < NUM_REQS; i++) begin
            gnt_ones_s = gnt_ones_s + CNTW'(bus.gnt[i]);
            if (bus.gnt[i]) begin
                gnt_idx_s   = IDXW'(i);
                gnt_cnt_s   = count_r[i];
                head_data_s = mem_r[i][rd_ptr_r[i]];
            end else begin
                gnt_idx_s   = gnt_idx_s;
                gnt_cnt_s   = gnt_cnt_s;
                head_data_s = head_data_s;
            end
        end
    end

    // A pop needs a one-hot grant to a non-empty queue; any other non-zero
    // grant is a protocol error. Grants are ignored while in reset.
    always_comb begin
        if (rst && (gnt_ones_s == ONE_GNT) && (gnt_cnt_s != ZERO_CNT)) begin
            pop_valid_s = 1'b1;
        end else begin
            pop_valid_s = 1'b0;
        end
        if (rst && (bus.gnt != {NUM_REQS{1'b0}}) && !pop_valid_s) begin
            gnt_bad_s = 1'b1;
        end else begin
            gnt_bad_s = 1'b0;
        end
    end

    // Per-queue push/pop strobes plus request and occupancy views, all
    // derived from registered counts (no fall-through to reqs).
    always_comb begin
        push_vec_s  = {NUM_REQS{1'b0}};
        pop_vec_s   = {NUM_REQS{1'b0}};
        reqs_s      = {NUM_REQS{1'b0}};
        occupancy_s = {(NUM_REQS*OCCW){1'b0}};
        for (int i = 0; i < NUM_REQS; i++) begin
            push_vec_s[i] = bus.in_valid & in_ready_s & (bus.in_flow == IDXW'(i));
            pop_vec_s[i]  = pop_valid_s & bus.gnt[i];
            reqs_s[i]     = (count_r[i] != ZERO_CNT);
            occupancy_s[i*OCCW +: OCCW] = count_r[i];
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Pointer and count update per queue; push and pop together leave the
    // count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                wr_ptr_r[i] <= ZERO_PTR;
                rd_ptr_r[i] <= ZERO_PTR;
                count_r[i]  <= ZERO_CNT;
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (push_vec_s[i]) begin
                    wr_ptr_r[i] <= ptr_inc(wr_ptr_r[i]);
                end
                if (pop_vec_s[i]) begin
                    rd_ptr_r[i] <= ptr_inc(rd_ptr_r[i]);
                end
                case ({push_vec_s[i], pop_vec_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + ONE_CNT;
                    2'b01:   count_r[i] <= count_r[i] - ONE_CNT;
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // Packet storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (push_vec_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= bus.in_data;
            end
        end
    end

    // Registered output port and sticky grant error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_flow_r  <= {IDXW{1'b0}};
            out_data_r  <= {DWID{1'b0}};
            gnt_err_r   <= 1'b0;
        end else begin
            out_valid_r <= pop_valid_s;
            if (pop_valid_s) begin
                out_flow_r <= gnt_idx_s;
                out_data_r <= head_data_s;
            end
            if (gnt_bad_s) begin
                gnt_err_r <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.reqs      = reqs_s;
    assign bus.occupancy = occupancy_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_flow  = out_flow_r;
    assign bus.out_data  = out_data_r;
    assign bus.gnt_err   = gnt_err_r;

endmodule

// File: doc/dwrr_flow_queues.md
Name: dwrr_flow_queues

Overview:
- Requestor side of the DWRR arbiter: NUM_REQS per-flow packet FIFOs.
- Each non-empty queue raises its reqs bit toward the arbiter.
- Consumes the arbiter's one-hot gnt, pops one packet from the granted flow, and presents it on a registered output port.
- Upstream packet sources enqueue by flow index through a valid/ready port.

Parameters:
- NUM_REQS, 4, number of flows/requestors; must be >= 2 and match the arbiter.
- DWID, 8, packet data width in bits.
- DEPTH, 4, entries per flow queue; must be >= 2 and need not be a power of 2.
- IDXW, $clog2(NUM_REQS), flow index width.
- OCCW, $clog2(DEPTH+1), per-queue occupancy width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream packet valid.
- in_flow  input  IDXW  destination flow of the upstream packet.
- in_data  input  DWID  upstream packet payload.
- in_ready  output  1  queue in_flow can accept; combinational.
- reqs  output  NUM_REQS  reqs[i]=1 iff queue i is non-empty; to arbiter.
- gnt  input  NUM_REQS  grant from arbiter; expected one-hot or zero.
- out_valid  output  1  dequeued packet valid (registered).
- out_flow  output  IDXW  flow the packet came from.
- out_data  output  DWID  dequeued packet payload.
- occupancy  output  NUM_REQS*OCCW  packed per-queue counts; queue i at [(i+1)*OCCW-1:i*OCCW].
- gnt_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst==0 at a clock edge):
  - All wr/rd pointers and counts go to 0, so reqs=0 and occupancy=0.
  - out_valid=0, out_flow=0, out_data=0, gnt_err=0.
  - Storage contents are don't-care.
  - While rst==0, in_ready=0 and gnt is ignored.
  - Reset mid-operation discards all queued packets and any pending output.
- Enqueue:
  - in_ready = rst & (count[in_flow] != DEPTH).
  - Push occurs when in_valid & in_ready; data is written at wr_ptr[in_flow], which then increments.
  - When in_ready==0 the packet is not accepted and nothing changes; the source holds it.
- reqs is derived only from registered counts. There is no fall-through: a push at edge t makes reqs high from cycle t+1.
- Pop:
  - Valid pop when gnt is one-hot, gnt[i]=1 and count[i]!=0.
  - Head entry (rd_ptr[i]) is registered to out_data, i to out_flow, and 1 to out_valid at the next edge. Latency is 1 cycle from grant to out_valid.
  - rd_ptr[i] increments and count[i] decrements.
  - out_valid=0 in any cycle without a valid pop; out_data/out_flow hold their last values.
- Pointer wrap: pointers run 0..DEPTH-1 and wrap explicitly to 0 on increment from DEPTH-1. No power-of-2 assumption.
- Simultaneous push and pop on the same queue:
  - Both take effect; count is unchanged; FIFO order is preserved.
  - in_ready is based on the pre-pop count, so a full queue refuses a push even if it is popped in the same cycle.
- Simultaneous push and pop on different queues are independent.
- Errors:
  - gnt to an empty queue, or more than one gnt bit set: no pop occurs, out_valid=0, gnt_err=1.
  - gnt_err stays set until reset.
- Counts never exceed DEPTH or drop below 0 under any stimulus.
- End-to-end latency: push edge t, reqs high t+1, arbiter gnt combinational in t+1, out_valid high t+2.

Test Plan:
- Reset: drive rst=0 for 2 cycles with arbitrary in_valid/gnt -> reqs=0000, out_valid=0, occupancy=0, gnt_err=0, in_ready=0.
- FIFO order: push 0xA1, 0xA2, 0xA3 to flow 2, then gnt=0100 for 3 cycles -> out_data A1, A2, A3 with out_flow=2 on consecutive cycles; reqs[2] falls after the third pop; occupancy[2] goes 3,2,1,0.
- Full: push 4 packets to flow 0 -> in_ready=0 for in_flow=0 and 1 for in_flow=1; an extra push to flow 0 is not accepted and occupancy[0] stays 4.
- Wrap/concurrency: with flow 1 holding 2 packets, push and gnt=0010 together for 6 cycles -> occupancy[1] stays 2 and the output sequence equals the input sequence delayed by 2 entries across pointer wrap. With flow 3 full, push and pop in the same cycle -> push refused, occupancy 3.
- Errors: gnt=0010 with flow 1 empty -> no out_valid and gnt_err=1. gnt=0011 with both flows non-empty -> no pop and gnt_err=1. gnt_err stays 1 until rst=0.
- Reset mid-stream: with 3 queues non-empty and out_valid=1, assert rst=0 for one cycle -> next cycle all reqs=0, out_valid=0, occupancy=0; a subsequent push and grant works normally.
